// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus: the broadcast payload layout and
// small sizing helpers used by the arbiter and its interface.
package cdb_arbiter_pkg;

    localparam int RSV_ID_W = 5;
    localparam int DATA_W   = 32;

    typedef struct packed {
        logic [RSV_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
    } cdb_t;

    localparam int CDB_W = $bits(cdb_t);

    // Pointer width for n requesters; a single requester still gets one bit.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle between the functional-unit result ports and the CDB arbiter,
// including the broadcast side and the utilisation counter.
interface cdb_arbiter_if
    import cdb_arbiter_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int CDB_W   = cdb_arbiter_pkg::CDB_W,
    parameter int CNT_W   = 32
);

    logic                       flush;
    logic [N_UNITS*CDB_W-1:0]   units_cdb;
    logic [N_UNITS-1:0]         units_cdb_valid;
    logic [N_UNITS-1:0]         units_cdb_ready;
    logic [CDB_W-1:0]           cdb;
    logic                       cdb_valid;
    logic [CNT_W-1:0]           cdb_busy_cnt;

    modport master (
        output flush,
        output units_cdb,
        output units_cdb_valid,
        input  units_cdb_ready,
        input  cdb,
        input  cdb_valid,
        input  cdb_busy_cnt
    );

    modport slave (
        input  flush,
        input  units_cdb,
        input  units_cdb_valid,
        output units_cdb_ready,
        output cdb,
        output cdb_valid,
        output cdb_busy_cnt
    );

endinterface

// File: rtl/cdb_arbiter_rr_priority_encoder.sv
// Combinational round-robin find-first: rotate the request vector so the
// pointer lands at bit 0, pick the lowest set bit, then rotate the index back.
module rr_priority_encoder
    import cdb_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    logic [PW-1:0]  off;
    logic [PW:0]    sum;

    always_comb begin
        req2 = {req, req};
        rot  = N'(req2 >> ptr);
        any  = |rot;
        off  = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = PW'(i);
        end
        // ptr < N and off < N, so a single conditional subtract wraps the sum
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
        gnt_idx = any ? PW'(sum) : '0;
        gnt     = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = any && (gnt_idx == PW'(i));
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing the single common data bus among the
// functional-unit result ports; the winner is registered onto cdb.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_UNITS = 4,
    parameter int CNT_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    cdb_arbiter_if.slave  cdb_bus
);

    localparam int PTR_W = ptr_w(N_UNITS);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   gnt_idx_p0;
    logic [N_UNITS-1:0] gnt_p0;
    logic               any_p0;
    logic               fire_p0;
    cdb_t               sel_p0;

    cdb_t               cdb_p1;
    logic               vld_p1;
    logic [CNT_W-1:0]   busy_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    rr_priority_encoder #(
        .N  (N_UNITS),
        .PW (PTR_W)
    ) u_enc (
        .req     (cdb_bus.units_cdb_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt_p0),
        .gnt_idx (gnt_idx_p0),
        .any     (any_p0)
    );

    // Grant stage: flush and reset both suppress the grant outright
    assign fire_p0                 = any_p0 & ~cdb_bus.flush & ~rst;
    assign cdb_bus.units_cdb_ready = fire_p0 ? gnt_p0 : '0;

    always_comb begin
        sel_p0 = '0;
        for (int i = 0; i < N_UNITS; i++) begin
            if (gnt_p0[i]) sel_p0 = sel_p0 | cdb_t'(cdb_bus.units_cdb[i*CDB_W +: CDB_W]);
        end
    end

    always_comb begin
        if (gnt_idx_p0 == PTR_W'(N_UNITS - 1)) ptr_next = '0;
        else                                   ptr_next = gnt_idx_p0 + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rr_ptr <= '0;
        else if (fire_p0) rr_ptr <= ptr_next;
    end

    // Broadcast stage: cdb is zeroed on idle cycles so tag compares need no gating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cdb_p1 <= '0;
        end else begin
            vld_p1 <= fire_p0;
            cdb_p1 <= fire_p0 ? sel_p0 : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         busy_cnt <= '0;
        else if (vld_p1) busy_cnt <= sat_inc(busy_cnt);
    end

    assign cdb_bus.cdb          = cdb_p1;
    assign cdb_bus.cdb_valid    = vld_p1;
    assign cdb_bus.cdb_busy_cnt = busy_cnt;

    a_ready_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(cdb_bus.units_cdb_ready));

    a_ready_needs_valid: assert property (@(posedge clk) disable iff (rst)
        (cdb_bus.units_cdb_ready & ~cdb_bus.units_cdb_valid) == '0);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: a 4-unit instance for the main checks
// and a 1-unit instance with a 2-bit counter for the degenerate/saturating case.
module tb_cdb_arbiter;
    import cdb_arbiter_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic v;
        cdb_t d;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_UNITS(N), .CDB_W(CDB_W), .CNT_W(32)) bus ();
    cdb_arbiter_if #(.N_UNITS(1), .CDB_W(CDB_W), .CNT_W(2))  bus1 ();

    cdb_arbiter #(.N_UNITS(N), .CNT_W(32)) u_dut  (.clk(clk), .rst(rst), .cdb_bus(bus));
    cdb_arbiter #(.N_UNITS(1), .CNT_W(2))  u_dut1 (.clk(clk), .rst(rst), .cdb_bus(bus1));

    int     n_checks = 0;
    int     n_pass   = 0;

    cdb_t       pay [N];
    logic [N-1:0] vld;
    logic       flush;

    int     m_ptr;
    sb_t    exp_q [$];
    sb_t    m_cur;
    longint m_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic drive();
        bus.units_cdb_valid = vld;
        bus.flush           = flush;
        for (int i = 0; i < N; i++) bus.units_cdb[i*CDB_W +: CDB_W] = pay[i];
    endtask

    task automatic model_reset();
        m_ptr = 0;
        exp_q.delete();
        m_cur = '0;
        m_cnt = 0;
    endtask

    task automatic do_reset();
        vld   = '0;
        flush = 1'b0;
        drive();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One clock: reference grant at the falling edge, output check after the rising edge.
    task automatic run_cycle(output int g);
        sb_t e;
        int  u;
        drive();
        @(negedge clk);
        g = -1;
        if (!flush) begin
            for (int k = 0; k < N; k++) begin
                u = (m_ptr + k) % N;
                if (g < 0 && vld[u]) g = u;
            end
        end
        chk("ready", 64'(bus.units_cdb_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        e = '0;
        if (g >= 0) begin
            e.v   = 1'b1;
            e.d   = pay[g];
            m_ptr = (g + 1) % N;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (m_cur.v) m_cnt++;
        m_cur = exp_q.pop_front();
        chk("cdb_valid", 64'(bus.cdb_valid), 64'(m_cur.v));
        chk("cdb", 64'(bus.cdb), 64'(m_cur.d));
        chk("busy_cnt", 64'(bus.cdb_busy_cnt), 64'(m_cnt));
        chk("rr_ptr", 64'(u_dut.rr_ptr), 64'(m_ptr));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int           g;
        logic [N-1:0] pend;
        int           wt [N];
        logic [7:0]   v1_seq;
        logic [7:0]   f1_seq;
        sb_t          q1 [$];
        sb_t          cur1;
        sb_t          e1;
        int           cnt1;
        cdb_t         p1;
        logic         r1;

        bus1.units_cdb_valid = 1'b0;
        bus1.flush           = 1'b0;
        bus1.units_cdb       = '0;

        // Reset state, with requests already presented
        for (int i = 0; i < N; i++) pay[i] = cdb_t'({RSV_ID_W'(i), 32'hC0DE_0000 + 32'(i)});
        vld   = '1;
        flush = 1'b0;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.units_cdb_ready), 64'd0);
        chk("rst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("rst_cdb", 64'(bus.cdb), 64'd0);
        chk("rst_busy_cnt", 64'(bus.cdb_busy_cnt), 64'd0);
        chk("rst_rr_ptr", 64'(u_dut.rr_ptr), 64'd0);
        rst = 1'b0;
        model_reset();

        // Single requester on unit 2
        vld    = 4'b0100;
        pay[2] = cdb_t'({5'd5, 32'h0000_1234});
        run_cycle(g);
        chk("t2_grant", 64'(g), 64'd2);
        chk("t2_cdb", 64'(bus.cdb), 64'({5'd5, 32'h0000_1234}));
        chk("t2_rr_ptr", 64'(u_dut.rr_ptr), 64'd3);

        // Wrap and skip from pointer 3
        vld    = 4'b0011;
        pay[0] = cdb_t'({5'd1, 32'hAAAA_0000});
        pay[1] = cdb_t'({5'd2, 32'hBBBB_0000});
        run_cycle(g);
        chk("t4_first", 64'(g), 64'd0);
        pay[0] = cdb_t'({5'd3, 32'hAAAA_0001});
        run_cycle(g);
        chk("t4_second", 64'(g), 64'd1);
        chk("t4_rr_ptr", 64'(u_dut.rr_ptr), 64'd2);
        vld = '0;
        run_cycle(g);

        // Full load from reset: strict rotation
        do_reset();
        vld = '1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) pay[i] = cdb_t'({RSV_ID_W'(i), 32'(c * 16 + i)});
            run_cycle(g);
            chk("rr_order", 64'(g), 64'(c % N));
        end
        vld = '0;
        run_cycle(g);
        chk("t3_busy_cnt", 64'(bus.cdb_busy_cnt), 64'd8);

        // Flush pulse in the middle of a full load
        vld = '1;
        run_cycle(g);
        run_cycle(g);
        flush = 1'b1;
        run_cycle(g);
        chk("flush_no_grant", 64'(g < 0), 64'd1);
        flush = 1'b0;
        run_cycle(g);
        chk("flush_resume", 64'(g), 64'd2);

        // Reset asserted while the bus is busy
        run_cycle(g);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_cdb_valid", 64'(bus.cdb_valid), 64'd0);
        chk("midrst_cdb", 64'(bus.cdb), 64'd0);
        chk("midrst_ready", 64'(bus.units_cdb_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("midrst_ready_hold", 64'(bus.units_cdb_ready), 64'd0);
        chk("midrst_busy_cnt", 64'(bus.cdb_busy_cnt), 64'd0);
        rst = 1'b0;
        model_reset();

        // Random requesters holding data until granted
        pend = '0;
        vld  = '0;
        for (int i = 0; i < N; i++) wt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int u = 0; u < N; u++) begin
                if (!pend[u] && $urandom_range(0, 2) != 0) begin
                    pend[u] = 1'b1;
                    pay[u]  = cdb_t'({RSV_ID_W'($urandom), 32'($urandom)});
                    wt[u]   = 0;
                end
            end
            vld = pend;
            run_cycle(g);
            if (g >= 0) begin
                chk("wait_bound", 64'(wt[g] < N), 64'd1);
                pend[g] = 1'b0;
            end
            for (int u = 0; u < N; u++) if (pend[u]) wt[u]++;
        end
        vld = '0;
        run_cycle(g);

        // Single-unit instance: ready follows valid, flush gates, counter saturates at 3
        do_reset();
        v1_seq = 8'b1111_1011;
        f1_seq = 8'b0000_1000;
        cur1   = '0;
        cnt1   = 0;
        for (int c = 0; c < 8; c++) begin
            p1 = cdb_t'({RSV_ID_W'(c), 32'hA0 + 32'(c)});
            bus1.units_cdb_valid = v1_seq[c];
            bus1.flush           = f1_seq[c];
            bus1.units_cdb       = p1;
            @(negedge clk);
            r1 = v1_seq[c] & ~f1_seq[c];
            chk("n1_ready", 64'(bus1.units_cdb_ready), 64'(r1));
            e1.v = r1;
            e1.d = r1 ? p1 : '0;
            q1.push_back(e1);
            @(posedge clk);
            #1;
            if (cur1.v && cnt1 < 3) cnt1++;
            cur1 = q1.pop_front();
            chk("n1_cdb_valid", 64'(bus1.cdb_valid), 64'(cur1.v));
            chk("n1_cdb", 64'(bus1.cdb), 64'(cur1.d));
            chk("n1_busy_cnt", 64'(bus1.cdb_busy_cnt), 64'(cnt1));
            chk("n1_rr_ptr", 64'(u_dut1.rr_ptr), 64'd0);
        end
        chk("n1_saturated", 64'(bus1.cdb_busy_cnt), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
